// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: handshake, wait states, byte-laned word RAM, held response
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane, eff_lane;
  logic                  in_range, misalign, err;
  logic [3:0]            be;
  logic [31:0]           wlanes, rd_word, merged, shifted, load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_nx   = 4'd0;
          state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) state_nx = S_ACCESS;
        else                  cnt_nx   = cnt + 4'd1;
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decode works on the latched request so req_* may change after acceptance.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    widx     = off[ADDR_WIDTH+1:2];
    lane     = off[1:0];
    in_range = ((off >> (ADDR_WIDTH + 2)) == 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((size_q == 2'b01) && lane[0]) || ((size_q == 2'b10) && (lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    err = !in_range || (size_q == 2'b11) || misalign;

    eff_lane = 2'b00;
    be       = 4'b0000;
    wlanes   = wdata_q;
    case (size_q)
      2'b00: begin
        eff_lane = lane;
        be       = 4'b0001 << lane;
        wlanes   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        eff_lane = {lane[1], 1'b0};
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    rd_word = mem[widx];
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? wlanes[8*b +: 8] : rd_word[8*b +: 8];

    shifted = rd_word >> {eff_lane, 3'b000};
    case (size_q)
      2'b00:   load_data = {24'd0, shifted[7:0]};
      2'b01:   load_data = {16'd0, shifted[15:0]};
      2'b10:   load_data = shifted;
      default: load_data = 32'd0;
    endcase
  end

  // RAM has no reset; writes happen only in ACCESS, so a reset before then drops the store.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && we_q && !err)
      mem[widx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      size_q    <= 2'b00;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
      if (state == S_ACCESS) begin
        rsp_err   <= err;
        rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
      end
    end
  end

endmodule
